ws2812_encoder: RTL and testbench

WS2812_ENCODER -- requirements
Module: ws2812_encoder

---
 rtl/ws2812_encoder_if.sv | 27 ++
 rtl/ws2812_encoder.sv | 160 ++++++++++++++++
 tb/tb_ws2812_encoder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_encoder_if.sv
// ws2812_encoder_if
// Byte stream from the SPI receive stage into the WS2812 encoder.
//   in_data  : pixel byte, GRB order, MSB transmitted first
//   in_valid : in_data / in_last are valid this cycle
//   in_last  : in_data is the final byte of a frame
//   in_ready : encoder can accept a byte this cycle
// A byte moves on a rising clock edge where in_valid and in_ready are both high.
interface ws2812_encoder_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/ws2812_encoder.sv
// ws2812_encoder
// Serialises a byte stream into WS2812 single-wire timing. Each bit is one
// TBIT-cycle period that starts high for T0H ("0") or T1H ("1") cycles. A frame
// ends with TLATCH low cycles. A one-entry holding register lets the next byte
// wait while the current byte shifts, so that bytes follow each other with no gap.
// Ports:
//   clk      : 50 MHz master clock, rising edge
//   reset    : asynchronous, active-high reset
//   in_bus   : byte stream (slave side of ws2812_encoder_if)
//   out      : registered WS2812 serial line
//   busy     : high whenever the encoder is not idle
//   underrun : one-cycle pulse when a frame runs dry before its last byte
module ws2812_encoder #(
    parameter int T0H    = 20,
    parameter int T1H    = 40,
    parameter int TBIT   = 63,
    parameter int TLATCH = 2750
) (
    input  logic              clk,
    input  logic              reset,
    ws2812_encoder_if.slave   in_bus,
    output logic              out,
    output logic              busy,
    output logic              underrun
);

    localparam int MAXC = (TBIT > TLATCH) ? TBIT : TLATCH;
    localparam int CW   = ($clog2(MAXC) < 12) ? 12 : $clog2(MAXC);

    localparam logic [CW-1:0] TBIT_END   = CW'(TBIT - 1);
    localparam logic [CW-1:0] TLATCH_END = CW'(TLATCH - 1);
    localparam logic [CW-1:0] T0H_C      = CW'(T0H);
    localparam logic [CW-1:0] T1H_C      = CW'(T1H);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    state_t         state, state_nxt;
    logic [7:0]     hold_data, hold_data_nxt;
    logic           hold_last, hold_last_nxt;
    logic           hold_full, hold_full_nxt;
    logic [7:0]     shift_reg, shift_nxt;
    logic           last_flag, last_flag_nxt;
    logic [2:0]     bit_idx, bit_idx_nxt;
    logic [CW-1:0]  counter, counter_nxt;
    logic [CW-1:0]  bit_high;
    logic           out_nxt;
    logic           underrun_nxt;
    logic           load;

    // in_ready depends only on a register, so there is no path from in_valid.
    assign in_bus.in_ready = ~hold_full;
    assign busy            = (state != IDLE);

    // State and datapath registers. out and underrun are registered, so the
    // line lags the state/counter by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            hold_data <= 8'h00;
            hold_last <= 1'b0;
            hold_full <= 1'b0;
            shift_reg <= 8'h00;
            last_flag <= 1'b0;
            bit_idx   <= 3'd7;
            counter   <= '0;
            out       <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_data <= hold_data_nxt;
            hold_last <= hold_last_nxt;
            hold_full <= hold_full_nxt;
            shift_reg <= shift_nxt;
            last_flag <= last_flag_nxt;
            bit_idx   <= bit_idx_nxt;
            counter   <= counter_nxt;
            out       <= out_nxt;
            underrun  <= underrun_nxt;
        end
    end

    // Next-state logic. The current bit is always shift_reg[7]; the register
    // shifts left once per bit period. A load from the holding register happens
    // when leaving IDLE and at the end of a byte when more data is waiting.
    always_comb begin
        state_nxt     = state;
        hold_data_nxt = hold_data;
        hold_last_nxt = hold_last;
        hold_full_nxt = hold_full;
        shift_nxt     = shift_reg;
        last_flag_nxt = last_flag;
        bit_idx_nxt   = bit_idx;
        counter_nxt   = counter;
        underrun_nxt  = 1'b0;
        load          = 1'b0;
        bit_high      = shift_reg[7] ? T1H_C : T0H_C;
        out_nxt       = (state == SHIFT) && (counter < bit_high);

        case (state)
            IDLE: begin
                if (hold_full) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (counter == TBIT_END) begin
                    counter_nxt = '0;
                    if (bit_idx != 3'd0) begin
                        bit_idx_nxt = bit_idx - 3'd1;
                        shift_nxt   = {shift_reg[6:0], 1'b0};
                    end else if (last_flag) begin
                        state_nxt   = LATCH;
                        bit_idx_nxt = 3'd7;
                    end else if (hold_full) begin
                        load = 1'b1;
                    end else begin
                        underrun_nxt = 1'b1;
                        state_nxt    = LATCH;
                        bit_idx_nxt  = 3'd7;
                    end
                end else begin
                    counter_nxt = counter + 1'b1;
                end
            end
            LATCH: begin
                if (counter == TLATCH_END) begin
                    state_nxt   = IDLE;
                    counter_nxt = '0;
                end else begin
                    counter_nxt = counter + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (load) begin
            shift_nxt     = hold_data;
            last_flag_nxt = hold_last;
            hold_full_nxt = 1'b0;
            bit_idx_nxt   = 3'd7;
            counter_nxt   = '0;
        end

        // Acceptance needs an empty holding register, so it never collides
        // with a load on the same edge.
        if (in_bus.in_valid && !hold_full) begin
            hold_data_nxt = in_bus.in_data;
            hold_last_nxt = in_bus.in_last;
            hold_full_nxt = 1'b1;
        end
    end

endmodule

// File: tb/tb_ws2812_encoder.sv
// tb_ws2812_encoder
// Self-checking bench for ws2812_encoder. Stimulus pushes one expected pulse
// description per transmitted bit into a queue; a monitor measures every high
// pulse and the low time that follows it on the serial line and pops and
// compares against the queue.
module tb_ws2812_encoder;

    localparam int T0H    = 20;
    localparam int T1H    = 40;
    localparam int TBIT   = 63;
    localparam int TLATCH = 2750;

    logic clk;
    logic reset;
    logic out;
    logic busy;
    logic underrun;

    ws2812_encoder_if io();

    ws2812_encoder #(
        .T0H    (T0H),
        .T1H    (T1H),
        .TBIT   (TBIT),
        .TLATCH (TLATCH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_bus   (io),
        .out      (out),
        .busy     (busy),
        .underrun (underrun)
    );

    typedef struct {
        int hi;
        int lo;
        int und;
        bit gap_check;
    } exp_item_t;

    exp_item_t exp_q[$];
    int num_compared = 0;
    int num_failed   = 0;

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #(20 * 80000);
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        num_compared++;
        if (actual != expected) begin
            num_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Queue the eight expected pulses of a byte, then offer it and wait for it to be taken.
    task automatic applyStimulus(input logic [7:0] data, input logic last,
                                 input bit exp_under, input bit gap_check,
                                 input bit keep_valid);
        int wait_cnt;
        exp_item_t e;
        for (int i = 7; i >= 0; i--) begin
            e.hi        = data[i] ? T1H : T0H;
            e.und       = (i == 0 && exp_under) ? 1 : 0;
            e.gap_check = (i == 0) && gap_check;
            if (i == 0 && (last || exp_under))
                e.lo = TBIT - e.hi + TLATCH - 1;
            else
                e.lo = TBIT - e.hi;
            exp_q.push_back(e);
        end
        io.in_data  = data;
        io.in_last  = last;
        io.in_valid = 1'b1;
        wait_cnt = 0;
        while (!io.in_ready && wait_cnt < 2000) begin
            @(posedge clk);
            #1;
            wait_cnt++;
        end
        if (!io.in_ready) begin
            checkOutput("accept_timeout", 0, 1);
            io.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            checkOutput("in_ready_after_accept", int'(io.in_ready), 0);
            if (!keep_valid)
                io.in_valid = 1'b0;
        end
    endtask

    task automatic waitIdle();
        int cnt;
        cnt = 0;
        while ((exp_q.size() != 0 || busy) && cnt < 10000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        checkOutput("drain_done", int'(exp_q.size() == 0 && !busy), 1);
        repeat (5) @(posedge clk);
        #1;
    endtask

    // Monitor: measures each high pulse, then the low run that follows it up
    // to the next rise or to the encoder returning to idle.
    initial begin : monitor
        bit have_rise;
        int hi, lo, und, gap;
        exp_item_t e;
        have_rise = 1'b0;
        forever begin
            if (!have_rise) begin
                @(negedge clk);
                if (reset || !out) continue;
            end
            have_rise = 1'b0;
            hi = 0;
            while (out && !reset && hi < 500) begin
                hi++;
                @(negedge clk);
            end
            if (reset) continue;
            lo  = 0;
            und = 0;
            while (!reset && !out && busy && lo < 5000) begin
                lo++;
                if (underrun) und++;
                @(negedge clk);
            end
            if (reset) continue;
            if (out) have_rise = 1'b1;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_pulse", hi, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("high_time", hi, e.hi);
                checkOutput("low_time", lo, e.lo);
                checkOutput("underrun_pulses", und, e.und);
                if (e.gap_check && !out) begin
                    gap = 0;
                    while (!out && !reset && gap < 200) begin
                        @(negedge clk);
                        gap++;
                    end
                    if (!reset) begin
                        checkOutput("idle_to_high_gap", gap, 2);
                        if (out) have_rise = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        reset       = 1'b1;
        io.in_valid = 1'b0;
        io.in_data  = 8'h00;
        io.in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out", int'(out), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_underrun", int'(underrun), 0);
        checkOutput("reset_in_ready", int'(io.in_ready), 1);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] single byte 0xA5 with last");
        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        waitIdle();

        $display("[TB] back-to-back 0xFF 0x00 0x81, in_valid held");
        applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
        waitIdle();

        $display("[TB] byte 0x80 without last, starved");
        applyStimulus(8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
        waitIdle();

        $display("[TB] reset mid-frame");
        applyStimulus(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (99) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midreset_out", int'(out), 0);
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_underrun", int'(underrun), 0);
        checkOutput("midreset_in_ready", int'(io.in_ready), 1);
        exp_q.delete();
        io.in_data  = 8'h55;
        io.in_last  = 1'b1;
        io.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        checkOutput("transfer_in_reset_ignored", int'(io.in_ready), 1);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idle_after_reset", int'(busy), 0);
        applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        waitIdle();

        $display("[TB] byte offered during latch");
        applyStimulus(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (600) @(posedge clk);
        #1;
        checkOutput("busy_in_latch", int'(busy), 1);
        applyStimulus(8'hE7, 1'b1, 1'b0, 1'b0, 1'b0);
        waitIdle();

        checkOutput("queue_empty_at_end", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_failed);
        $finish;
    end

endmodule
